// File: rtl/datapath_pipe_if.sv
// Issue-side bundle between the control unit and datapath_pipe, plus the
// bypassed read ports and the writeback-stage outputs.
interface datapath_pipe_if #(
   parameter int DATA_W    = 8,
   parameter int REG_COUNT = 16
);
   localparam int ADDR_W = $clog2(REG_COUNT);

   logic              issue_valid;
   logic              issue_ready;
   logic [2:0]        alu_opcode;
   logic [ADDR_W-1:0] ra_addr;
   logic [ADDR_W-1:0] rb_addr;
   logic [ADDR_W-1:0] write_addr;
   logic              write_en;
   logic              is_load;
   logic              imm_flag;
   logic [DATA_W-1:0] imm_data;
   logic [DATA_W-1:0] ram_data;
   logic [DATA_W-1:0] read_a;
   logic [DATA_W-1:0] read_b;
   logic [DATA_W-1:0] alu_out;
   logic              alu_zero;
   logic              alu_carry;
   logic              wb_valid;

   modport master (
      output issue_valid, alu_opcode, ra_addr, rb_addr, write_addr, write_en,
             is_load, imm_flag, imm_data, ram_data,
      input  issue_ready, read_a, read_b, alu_out, alu_zero, alu_carry, wb_valid
   );

   modport slave (
      input  issue_valid, alu_opcode, ra_addr, rb_addr, write_addr, write_en,
             is_load, imm_flag, imm_data, ram_data,
      output issue_ready, read_a, read_b, alu_out, alu_zero, alu_carry, wb_valid
   );
endinterface

// File: rtl/datapath_pipe.sv
// Two-stage datapath: register file with writeback bypass, 8-op ALU, and a
// one-bit-per-cycle sequencer for multi-bit SHL/SHR.
module datapath_pipe #(
   parameter int DATA_W    = 8,
   parameter int REG_COUNT = 16
) (
   input  logic           clk,
   input  logic           rst,
   datapath_pipe_if.slave bus
);
   localparam int ADDR_W = $clog2(REG_COUNT);
   localparam int CNT_W  = $clog2(DATA_W);

   typedef enum logic {S_IDLE, S_SHIFT} state_e;
   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR
   } op_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] regs_q [REG_COUNT];
   logic [DATA_W-1:0] regs_d [REG_COUNT];
   logic [DATA_W-1:0] alu_out_q, alu_out_d;
   logic              zero_q, zero_d;
   logic              carry_q, carry_d;
   logic              wb_valid_q, wb_valid_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic              wb_we_q, wb_we_d;
   logic [DATA_W-1:0] sh_val_q, sh_val_d;
   logic              sh_left_q, sh_left_d;
   logic [CNT_W-1:0]  sh_cnt_q, sh_cnt_d;
   logic [ADDR_W-1:0] sh_addr_q, sh_addr_d;
   logic              sh_we_q, sh_we_d;

   op_e               op;
   logic              is_shift;
   logic              wb_fwd;
   logic [DATA_W-1:0] read_a_w, read_b_w, b_op;
   logic [CNT_W-1:0]  shift_n;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;
   logic [DATA_W-1:0] sh_next;
   logic              sh_out;

   assign op       = op_e'(bus.alu_opcode);
   assign is_shift = (op == OP_SHL) || (op == OP_SHR);

   // The value sitting in WB is not yet in the array, so reads forward it.
   assign wb_fwd   = wb_valid_q && wb_we_q;
   assign read_a_w = (wb_fwd && wb_addr_q == bus.ra_addr) ? alu_out_q : regs_q[bus.ra_addr];
   assign read_b_w = (wb_fwd && wb_addr_q == bus.rb_addr) ? alu_out_q : regs_q[bus.rb_addr];
   assign b_op     = bus.imm_flag ? bus.imm_data : read_b_w;
   assign shift_n  = CNT_W'(b_op % DATA_W'(DATA_W));

   assign sh_next = sh_left_q ? {sh_val_q[DATA_W-2:0], 1'b0} : {1'b0, sh_val_q[DATA_W-1:1]};
   assign sh_out  = sh_left_q ? sh_val_q[DATA_W-1] : sh_val_q[0];

   // NOTE: every output of a combinational block gets a default before the
   // case, otherwise an unassigned path infers a latch.
   always_comb begin
      sum     = {1'b0, read_a_w} + {1'b0, b_op};
      alu_res = read_a_w;
      alu_c   = 1'b0;
      case (op)
         OP_ADD:  {alu_c, alu_res} = sum;
         OP_SUB:  begin
                     alu_res = read_a_w - b_op;
                     alu_c   = read_a_w < b_op;
                  end
         OP_AND:  alu_res = read_a_w & b_op;
         OP_OR:   alu_res = read_a_w | b_op;
         OP_XOR:  alu_res = read_a_w ^ b_op;
         OP_NOT:  alu_res = ~read_a_w;
         default: alu_res = read_a_w;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      regs_d     = regs_q;
      alu_out_d  = alu_out_q;
      zero_d     = zero_q;
      carry_d    = carry_q;
      wb_valid_d = 1'b0;
      wb_addr_d  = wb_addr_q;
      wb_we_d    = wb_we_q;
      sh_val_d   = sh_val_q;
      sh_left_d  = sh_left_q;
      sh_cnt_d   = sh_cnt_q;
      sh_addr_d  = sh_addr_q;
      sh_we_d    = sh_we_q;

      if (wb_fwd) regs_d[wb_addr_q] = alu_out_q;

      case (state_q)
         S_IDLE: if (bus.issue_valid) begin
            if (!bus.is_load && is_shift && shift_n != '0) begin
               sh_val_d  = read_a_w;
               sh_left_d = (op == OP_SHL);
               sh_cnt_d  = shift_n;
               sh_addr_d = bus.write_addr;
               sh_we_d   = bus.write_en;
               state_d   = S_SHIFT;
            end else begin
               wb_valid_d = 1'b1;
               wb_addr_d  = bus.write_addr;
               wb_we_d    = bus.write_en;
               if (bus.is_load) begin
                  alu_out_d = bus.ram_data;
               end else begin
                  alu_out_d = alu_res;
                  zero_d    = (alu_res == '0);
                  carry_d   = alu_c;
               end
            end
         end
         S_SHIFT: begin
            sh_val_d = sh_next;
            sh_cnt_d = sh_cnt_q - 1'b1;
            if (sh_cnt_q == CNT_W'(1)) begin
               state_d    = S_IDLE;
               wb_valid_d = 1'b1;
               wb_addr_d  = sh_addr_q;
               wb_we_d    = sh_we_q;
               alu_out_d  = sh_next;
               zero_d     = (sh_next == '0);
               carry_d    = sh_out;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments for all state so every flop samples the
   // pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         // NOTE: the register file is architecturally cleared by reset, so it
         // is built from resettable flops rather than a RAM macro.
         regs_q     <= '{default: '0};
         alu_out_q  <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_we_q    <= 1'b0;
         sh_val_q   <= '0;
         sh_left_q  <= 1'b0;
         sh_cnt_q   <= '0;
         sh_addr_q  <= '0;
         sh_we_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         regs_q     <= regs_d;
         alu_out_q  <= alu_out_d;
         zero_q     <= zero_d;
         carry_q    <= carry_d;
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_we_q    <= wb_we_d;
         sh_val_q   <= sh_val_d;
         sh_left_q  <= sh_left_d;
         sh_cnt_q   <= sh_cnt_d;
         sh_addr_q  <= sh_addr_d;
         sh_we_q    <= sh_we_d;
      end
   end

   assign bus.issue_ready = (state_q == S_IDLE) && !rst;
   assign bus.read_a      = read_a_w;
   assign bus.read_b      = read_b_w;
   assign bus.alu_out     = alu_out_q;
   assign bus.alu_zero    = zero_q;
   assign bus.alu_carry   = carry_q;
   assign bus.wb_valid    = wb_valid_q;
endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: directed scenarios plus random ops checked against
// an architectural model (register array + flags, shifts by plain arithmetic).
module tb_datapath_pipe;
   logic clk = 1'b0;
   logic rst;
   logic rst16;
   always #5 clk = ~clk;

   datapath_pipe_if #(.DATA_W(8), .REG_COUNT(16)) bus ();
   datapath_pipe #(.DATA_W(8), .REG_COUNT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   datapath_pipe_if #(.DATA_W(16), .REG_COUNT(32)) bus16 ();
   datapath_pipe #(.DATA_W(16), .REG_COUNT(32)) dut16 (.clk(clk), .rst(rst16), .bus(bus16));

   logic [7:0] m_regs [16];
   logic       m_zero, m_carry;
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                     output logic [7:0] res, output logic c);
      int ai, bi, n, full;
      ai = int'(a);
      bi = int'(b);
      n  = bi % 8;
      c  = 1'b0;
      res = 8'h00;
      case (op)
         3'd0: begin full = ai + bi; res = 8'(full); c = (full > 255); end
         3'd1: begin full = ai - bi; res = 8'(full); c = (ai < bi); end
         3'd2: res = a & b;
         3'd3: res = a | b;
         3'd4: res = a ^ b;
         3'd5: res = ~a;
         3'd6: begin full = ai << n; res = 8'(full); c = (n != 0) && full[8]; end
         default: begin
            res = 8'(ai >> n);
            if (n != 0) c = ((ai >> (n - 1)) & 1) == 1;
         end
      endcase
   endfunction

   // Called at a negedge; returns at the negedge where the result is visible.
   task automatic do_op(input string tag, input logic [2:0] op, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [3:0] wa, input logic we,
                        input logic ld, input logic immf, input logic [7:0] imm,
                        input logic [7:0] ram);
      logic [7:0] a, b, res;
      logic       c;
      int         n, busy;
      bus.alu_opcode = op;  bus.ra_addr  = ra;   bus.rb_addr  = rb;
      bus.write_addr = wa;  bus.write_en = we;   bus.is_load  = ld;
      bus.imm_flag   = immf; bus.imm_data = imm; bus.ram_data = ram;
      bus.issue_valid = 1'b1;
      #1;
      check({tag, ".read_a"}, 32'(bus.read_a), 32'(m_regs[ra]));
      check({tag, ".read_b"}, 32'(bus.read_b), 32'(m_regs[rb]));
      check({tag, ".ready"},  32'(bus.issue_ready), 32'd1);
      a = m_regs[ra];
      b = immf ? imm : m_regs[rb];
      n = (!ld && op >= 3'd6) ? int'(b) % 8 : 0;
      c = 1'b0;
      if (ld) res = ram;
      else    model_alu(op, a, b, res, c);
      @(posedge clk);
      #1 bus.issue_valid = 1'b0;
      @(negedge clk);
      busy = 0;
      while (!bus.issue_ready && busy < 64) begin
         busy++;
         @(negedge clk);
      end
      check({tag, ".busy"}, 32'(busy), 32'(n));
      if (!ld) begin
         m_zero  = (res == 8'h00);
         m_carry = c;
      end
      if (we) m_regs[wa] = res;
      check({tag, ".alu_out"},  32'(bus.alu_out),   32'(res));
      check({tag, ".zero"},     32'(bus.alu_zero),  32'(m_zero));
      check({tag, ".carry"},    32'(bus.alu_carry), 32'(m_carry));
      check({tag, ".wb_valid"}, 32'(bus.wb_valid),  32'd1);
   endtask

   initial begin
      logic [31:0] wide;
      rst = 1'b1;
      rst16 = 1'b1;
      bus.issue_valid = 1'b0; bus.alu_opcode = 3'd0; bus.ra_addr = '0; bus.rb_addr = '0;
      bus.write_addr = '0; bus.write_en = 1'b0; bus.is_load = 1'b0; bus.imm_flag = 1'b0;
      bus.imm_data = '0; bus.ram_data = '0;
      bus16.issue_valid = 1'b0; bus16.alu_opcode = 3'd0; bus16.ra_addr = '0; bus16.rb_addr = '0;
      bus16.write_addr = '0; bus16.write_en = 1'b0; bus16.is_load = 1'b0; bus16.imm_flag = 1'b0;
      bus16.imm_data = '0; bus16.ram_data = '0;
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_zero = 1'b0;
      m_carry = 1'b0;

      // Reset: two edges with rst high.
      @(posedge clk);
      @(negedge clk);
      check("rst.ready_low", 32'(bus.issue_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst.alu_out",  32'(bus.alu_out),     32'd0);
      check("rst.zero",     32'(bus.alu_zero),    32'd0);
      check("rst.carry",    32'(bus.alu_carry),   32'd0);
      check("rst.wb_valid", 32'(bus.wb_valid),    32'd0);
      check("rst.ready",    32'(bus.issue_ready), 32'd1);
      for (int i = 0; i < 16; i++) begin
         bus.ra_addr = 4'(i);
         #1 check($sformatf("rst.reg%0d", i), 32'(bus.read_a), 32'd0);
      end

      // Immediate chain, back-to-back through the bypass.
      do_op("chain1", 3'd0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b1, 8'h7F, 8'h00);
      do_op("chain2", 3'd0, 4'd1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00);
      check("chain.r2_const", 32'(m_regs[2]), 32'h80);

      // Overflow and borrow.
      do_op("ovf.ld",  3'd0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00);
      do_op("ovf.add", 3'd0, 4'd3, 4'd0, 4'd6, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00);
      do_op("brw.ld",  3'd0, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 1'b1, 8'h03, 8'h00);
      do_op("brw.sub", 3'd1, 4'd7, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1, 8'h05, 8'h00);

      // Shift sequencer.
      do_op("sh.ld",   3'd0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b1, 8'h81, 8'h00);
      do_op("sh.shl3", 3'd6, 4'd1, 4'd0, 4'd9, 1'b1, 1'b0, 1'b1, 8'd3, 8'h00);
      do_op("sh.shr1", 3'd7, 4'd1, 4'd0, 4'd10, 1'b1, 1'b0, 1'b1, 8'd1, 8'h00);
      do_op("sh.shl8", 3'd6, 4'd1, 4'd0, 4'd11, 1'b1, 1'b0, 1'b1, 8'd8, 8'h00);
      do_op("sh.rd9",  3'd3, 4'd9, 4'd10, 4'd12, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

      // Load keeps flags from the preceding zero-result SUB.
      do_op("ldf.sub",  3'd1, 4'd1, 4'd1, 4'd11, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      do_op("ldf.load", 3'd0, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 8'h00, 8'h5A);
      do_op("ldf.rd4",  3'd2, 4'd4, 4'd4, 4'd5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      // Reset in the middle of a 7-bit shift aborts the writeback.
      bus.alu_opcode = 3'd6; bus.ra_addr = 4'd1; bus.write_addr = 4'd3; bus.write_en = 1'b1;
      bus.is_load = 1'b0; bus.imm_flag = 1'b1; bus.imm_data = 8'd7; bus.issue_valid = 1'b1;
      @(posedge clk);
      #1 bus.issue_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("abort.busy", 32'(bus.issue_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_zero = 1'b0;
      m_carry = 1'b0;
      @(negedge clk);
      check("abort.ready",    32'(bus.issue_ready), 32'd1);
      check("abort.wb_valid", 32'(bus.wb_valid),    32'd0);
      check("abort.alu_out",  32'(bus.alu_out),     32'd0);
      repeat (8) @(negedge clk);
      bus.ra_addr = 4'd3;
      #1 check("abort.r3", 32'(bus.read_a), 32'd0);
      check("abort.ready_late", 32'(bus.issue_ready), 32'd1);

      // Random traffic against the model.
      for (int k = 0; k < 60; k++) begin
         do_op($sformatf("rnd%0d", k), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
               8'($urandom));
      end
      for (int i = 0; i < 16; i++) begin
         bus.ra_addr = 4'(i);
         #1 check($sformatf("final.reg%0d", i), 32'(bus.read_a), 32'(m_regs[i]));
      end

      // Wider instance: ADD 0xFFFF + 1 wraps with carry.
      @(negedge clk);
      rst16 = 1'b0;
      @(negedge clk);
      check("w16.ready", 32'(bus16.issue_ready), 32'd1);
      bus16.alu_opcode = 3'd0; bus16.ra_addr = 5'd0; bus16.write_addr = 5'd1;
      bus16.write_en = 1'b1; bus16.imm_flag = 1'b1; bus16.imm_data = 16'hFFFF;
      bus16.issue_valid = 1'b1;
      @(negedge clk);
      check("w16.ld", 32'(bus16.alu_out), 32'hFFFF);
      bus16.ra_addr = 5'd1; bus16.write_addr = 5'd2; bus16.imm_data = 16'h0001;
      @(negedge clk);
      bus16.issue_valid = 1'b0;
      wide = 32'hFFFF + 32'h1;
      check("w16.sum",   32'(bus16.alu_out),   wide & 32'hFFFF);
      check("w16.carry", 32'(bus16.alu_carry), wide >> 16);
      check("w16.zero",  32'(bus16.alu_zero),  32'd1);
      repeat (2) @(negedge clk);
      bus16.ra_addr = 5'd1;
      #1 check("w16.r1", 32'(bus16.read_a), 32'hFFFF);
      bus16.ra_addr = 5'd2;
      #1 check("w16.r2", 32'(bus16.read_a), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
